// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding of the current multiplier bit and its history bit.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A,Q,Q_1}. A is one bit wider than the operand
// so that A-M cannot overflow when M is the most negative value.
module mult_booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q1_o
);

  booth_op_e      op;
  logic [WIDTH:0] sum;

  // Select add/sub/none, then shift the combined register right by one.
  always_comb begin
    op  = booth_decode(q_i[0], q1_i);
    sum = a_i;
    case (op)
      BOOTH_ADD: sum = a_i + m_i;
      BOOTH_SUB: sum = a_i - m_i;
      default:   sum = a_i;
    endcase
    a_o  = {sum[WIDTH], sum[WIDTH:1]};
    q_o  = {sum[0], q_i[WIDTH-1:1]};
    q1_o = q_i[0];
  end

endmodule

// File: rtl/mult.sv
// Sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier. One Booth step per
// cycle; mfhi/mflo are updated and done pulses once per completed operation.
module mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_init,
  input  logic [WIDTH-1:0] multiplicando,
  input  logic [WIDTH-1:0] multiplicador,
  output logic [WIDTH-1:0] mfhi,
  output logic [WIDTH-1:0] mflo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d, m_q, m_d, a_nxt;
  logic [WIDTH-1:0] q_q, q_d, q_nxt;
  logic             q1_q, q1_d, q1_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mfhi_q, mfhi_d, mflo_q, mflo_d;
  logic             busy_q, busy_d, done_q, done_d;

  mult_booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (a_nxt),
    .q_o  (q_nxt),
    .q1_o (q1_nxt)
  );

  // Next-state logic: load on init (also restarts a running op), step in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    count_d = count_q;
    mfhi_d  = mfhi_q;
    mflo_d  = mflo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (mult_init) begin
      m_d     = {multiplicando[WIDTH-1], multiplicando};
      q_d     = multiplicador;
      a_d     = '0;
      q1_d    = 1'b0;
      count_d = '0;
      busy_d  = 1'b1;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          a_d     = a_nxt;
          q_d     = q_nxt;
          q1_d    = q1_nxt;
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            mfhi_d  = a_nxt[WIDTH-1:0];
            mflo_d  = q_nxt;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
        default: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      mfhi_q  <= '0;
      mflo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      count_q <= count_d;
      mfhi_q  <= mfhi_d;
      mflo_q  <= mflo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mfhi = mfhi_q;
  assign mflo = mflo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for the sequential Booth multiplier.
module tb_mult;
  import mult_pkg::*;

  localparam int W = MULT_WIDTH;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mult_init = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic [W-1:0] mfhi, mflo;
  logic         busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] sb_q[$];

  mult dut (
    .clk           (clk),
    .reset         (reset),
    .mult_init     (mult_init),
    .multiplicando (opa),
    .multiplicador (opb),
    .mfhi          (mfhi),
    .mflo          (mflo),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe, ye;
    xe = {{W{x[W-1]}}, x};
    ye = {{W{y[W-1]}}, y};
    return xe * ye;
  endfunction

  // Present operands with mult_init for exactly one sampling edge.
  task automatic pulse(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    opa = x; opb = y; mult_init = 1'b1;
    @(negedge clk);
    mult_init = 1'b0;
  endtask

  // Wait for done, check latency, result and handshake, then the pulse width.
  task automatic wait_done(input string nm);
    int k;
    bit seen, overlap, busy_low;
    logic [2*W-1:0] exp;
    k = 0; seen = 0; overlap = 0; busy_low = 0;
    while (!seen && k < 2*W) begin
      @(negedge clk);
      k++;
      if (busy && done) overlap = 1;
      if (!done && busy !== 1'b1) busy_low = 1;
      if (done === 1'b1) seen = 1;
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen within %0d cycles", nm, 2*W);
      return;
    end
    n_tests++;
    if (k !== W) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, k, W); end
    n_tests++;
    if (mfhi !== exp[2*W-1:W]) begin n_fail++; $display("FAIL %s mfhi: got %h want %h", nm, mfhi, exp[2*W-1:W]); end
    n_tests++;
    if (mflo !== exp[W-1:0]) begin n_fail++; $display("FAIL %s mflo: got %h want %h", nm, mflo, exp[W-1:0]); end
    n_tests++;
    if (overlap || busy_low) begin n_fail++; $display("FAIL %s busy: overlap=%0d busy_dropped=%0d want 0/0", nm, overlap, busy_low); end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s after-done: done=%b busy=%b want 0/0", nm, done, busy); end
    n_tests++;
    if ({mfhi, mflo} !== exp) begin n_fail++; $display("FAIL %s hold: got %h want %h", nm, {mfhi, mflo}, exp); end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string nm);
    sb_q.push_back(ref_prod(x, y));
    pulse(x, y);
    wait_done(nm);
  endtask

  task automatic test_reset();
    bit bad;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({mfhi, mflo, busy, done} !== '0) begin n_fail++; $display("FAIL reset_state: got %h want 0", {mfhi, mflo, busy, done}); end
    reset = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if ({mfhi, mflo, busy, done} !== '0) bad = 1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL reset_idle: outputs left 0 with mult_init=0, got %h", {mfhi, mflo, busy, done}); end
  endtask

  task automatic test_basic();
    run_op(32'h0000_0007, 32'hFFFF_FFFD, "7x-3");
    n_tests++;
    if ({mfhi, mflo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL 7x-3_const: got %h want ffffffffffffffeb", {mfhi, mflo}); end
  endtask

  task automatic test_min_min();
    run_op(32'h8000_0000, 32'h8000_0000, "min_x_min");
    n_tests++;
    if ({mfhi, mflo} !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL min_x_min_const: got %h want 4000000000000000", {mfhi, mflo}); end
  endtask

  task automatic test_back_to_back();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "-1x-1");
    run_op(32'h7FFF_FFFF, 32'h0000_0002, "max_x2");
    n_tests++;
    if ({mfhi, mflo} !== 64'h0000_0000_FFFF_FFFE) begin n_fail++; $display("FAIL max_x2_const: got %h want 00000000fffffffe", {mfhi, mflo}); end
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = (i == 0) ? '0 : $urandom;
      run_op(x, y, "random");
    end
  endtask

  task automatic test_restart();
    bit early;
    pulse(32'd5, 32'd5);
    early = 0;
    repeat (9) begin
      @(negedge clk);
      if (done) early = 1;
    end
    sb_q.push_back(ref_prod(32'd6, 32'd7));
    pulse(32'd6, 32'd7);
    wait_done("restart");
    n_tests++;
    if (early || {mfhi, mflo} !== 64'd42) begin n_fail++; $display("FAIL restart_result: early_done=%0d got %h want 42", early, {mfhi, mflo}); end
  endtask

  task automatic test_reset_mid();
    bit spur;
    pulse(32'd3, 32'd4);
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({mfhi, mflo, busy, done} !== '0) begin n_fail++; $display("FAIL reset_mid: got %h want 0", {mfhi, mflo, busy, done}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    spur = 0;
    repeat (2*W) begin
      @(negedge clk);
      if (done || busy) spur = 1;
    end
    n_tests++;
    if (spur) begin n_fail++; $display("FAIL reset_mid_no_done: got done/busy activity, want none"); end
    run_op(32'd3, 32'd4, "3x4_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_min();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
